// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: stage occupancy encoding and default widths.
package pipe_stage_buf_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_CTRL_W = 8;
   localparam int unsigned DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_t;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Inc,
   input  logic             Clr,
   output logic [CNT_W-1:0] Count
);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Count <= '0;
      end else if (Clr) begin
         Count <= '0;
      end else if (Inc && (Count != '1)) begin
         Count <= Count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (main + skid) with flush, bubble masking
// of control bits and a saturating stall counter.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CTRL_W = DEF_CTRL_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [DATA_W-1:0] In_Data,
   input  logic [CTRL_W-1:0] In_Ctrl,
   input  logic              Flush,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Data,
   output logic [CTRL_W-1:0] Out_Ctrl,
   output logic [CNT_W-1:0]  Stall_Cnt,
   input  logic              Stall_Clr
);

   stage_state_t      state;
   logic              rdy_en;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              in_fire;
   logic              out_fire;

   // rdy_en keeps In_Ready low during reset and until the first edge after it.
   assign In_Ready  = rdy_en && (state != ST_FULL);
   assign Out_Valid = (state != ST_EMPTY);
   assign Out_Data  = main_data;
   assign Out_Ctrl  = main_ctrl & {CTRL_W{Out_Valid}};
   assign in_fire   = In_Valid && In_Ready;
   assign out_fire  = Out_Valid && Out_Ready;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= ST_EMPTY;
         rdy_en    <= 1'b0;
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (Flush) begin
            state <= ST_EMPTY;
         end else begin
            unique case (state)
               ST_EMPTY: begin
                  if (in_fire) begin
                     state     <= ST_ONE;
                     main_data <= In_Data;
                     main_ctrl <= In_Ctrl;
                  end
               end
               ST_ONE: begin
                  if (in_fire && !out_fire) begin
                     state     <= ST_FULL;
                     skid_data <= In_Data;
                     skid_ctrl <= In_Ctrl;
                  end else if (!in_fire && out_fire) begin
                     state <= ST_EMPTY;
                  end else if (in_fire && out_fire) begin
                     main_data <= In_Data;
                     main_ctrl <= In_Ctrl;
                  end
               end
               ST_FULL: begin
                  if (out_fire) begin
                     state     <= ST_ONE;
                     main_data <= skid_data;
                     main_ctrl <= skid_ctrl;
                  end
               end
               default: state <= ST_EMPTY;
            endcase
         end
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .Clk  (Clk),
      .Rst  (Rst),
      .Inc  (Out_Valid && !Out_Ready),
      .Clr  (Stall_Clr),
      .Count(Stall_Cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scoreboard bench for pipe_stage_buf (DATA_W=32, CTRL_W=8, CNT_W=4).
module tb_pipe_stage_buf;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [31:0] In_Data = '0;
   logic [7:0]  In_Ctrl = '0;
   logic        Flush = 1'b0;
   logic        Out_Valid;
   logic        Out_Ready = 1'b0;
   logic [31:0] Out_Data;
   logic [7:0]  Out_Ctrl;
   logic [3:0]  Stall_Cnt;
   logic        Stall_Clr = 1'b0;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  c;
   } entry_t;

   entry_t      sb[$];
   logic        m_rdy_en = 1'b0;
   int unsigned m_cnt = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 Clk = ~Clk;

   pipe_stage_buf #(
      .DATA_W(32),
      .CTRL_W(8),
      .CNT_W (4)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .In_Valid (In_Valid),
      .In_Ready (In_Ready),
      .In_Data  (In_Data),
      .In_Ctrl  (In_Ctrl),
      .Flush    (Flush),
      .Out_Valid(Out_Valid),
      .Out_Ready(Out_Ready),
      .Out_Data (Out_Data),
      .Out_Ctrl (Out_Ctrl),
      .Stall_Cnt(Stall_Cnt),
      .Stall_Clr(Stall_Clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check pre-edge outputs against the model, advance model.
   task automatic step(input logic iv, input logic [31:0] id, input logic [7:0] ic,
                       input logic ordy, input logic fl, input logic clr);
      logic   exp_rdy, exp_val, in_f, out_f;
      entry_t e;
      In_Valid  = iv;
      In_Data   = id;
      In_Ctrl   = ic;
      Out_Ready = ordy;
      Flush     = fl;
      Stall_Clr = clr;
      @(negedge Clk);
      exp_rdy = m_rdy_en && (sb.size() < 2);
      exp_val = (sb.size() > 0);
      chk("in_ready", {31'b0, In_Ready}, {31'b0, exp_rdy});
      chk("out_valid", {31'b0, Out_Valid}, {31'b0, exp_val});
      chk("stall_cnt", {28'b0, Stall_Cnt}, m_cnt);
      if (exp_val) begin
         chk("out_data", Out_Data, sb[0].d);
         chk("out_ctrl", {24'b0, Out_Ctrl}, {24'b0, sb[0].c});
      end else begin
         chk("bubble_ctrl", {24'b0, Out_Ctrl}, 32'h0);
      end
      in_f  = iv && exp_rdy;
      out_f = exp_val && ordy;
      @(posedge Clk);
      m_rdy_en = 1'b1;
      if (clr) m_cnt = 0;
      else if (exp_val && !ordy && m_cnt < 15) m_cnt++;
      if (fl) begin
         sb.delete();
      end else begin
         if (out_f) void'(sb.pop_front());
         if (in_f) begin
            e.d = id;
            e.c = ic;
            sb.push_back(e);
         end
      end
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'b0, Out_Valid}, 32'h0);
      chk({tag, "_ready"}, {31'b0, In_Ready}, 32'h0);
      chk({tag, "_data"}, Out_Data, 32'h0);
      chk({tag, "_ctrl"}, {24'b0, Out_Ctrl}, 32'h0);
      chk({tag, "_cnt"}, {28'b0, Stall_Cnt}, 32'h0);
   endtask

   initial begin
      // Reset held across edges
      repeat (2) @(posedge Clk);
      #1;
      chk_reset_outputs("rst");
      Rst = 1'b0;
      step(0, 32'h0, 8'h00, 1, 0, 0);   // In_Ready still low before first edge
      step(0, 32'h0, 8'h00, 1, 0, 0);

      // Streaming
      step(1, 32'h11, 8'h01, 1, 0, 0);
      step(1, 32'h22, 8'h02, 1, 0, 0);
      step(1, 32'h33, 8'h03, 1, 0, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);

      // Bubble: control asserted on an invalid input
      step(0, 32'hDEAD, 8'hFF, 1, 0, 0);
      step(0, 32'hDEAD, 8'hFF, 1, 0, 0);

      // Backpressure, A3 held upstream until accepted
      step(1, 32'hA1, 8'h5A, 0, 0, 0);
      step(1, 32'hA2, 8'h5B, 0, 0, 0);
      step(1, 32'hA3, 8'h5C, 0, 0, 0);
      step(1, 32'hA3, 8'h5C, 1, 0, 0);
      step(1, 32'hA3, 8'h5C, 1, 0, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);
      chk("a3_drained", sb.size(), 32'h0);
      step(0, 32'h0, 8'h00, 0, 0, 1);

      // Flush while FULL with a valid incoming entry
      step(1, 32'hB1, 8'h21, 0, 0, 0);
      step(1, 32'hB2, 8'h22, 0, 0, 0);
      step(1, 32'hB3, 8'h23, 0, 1, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);

      // Flush coinciding with out-fire
      step(1, 32'hC1, 8'h31, 0, 0, 1);
      step(1, 32'hC2, 8'h32, 0, 0, 0);
      step(1, 32'hC3, 8'h33, 1, 1, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);

      // Stall counter saturation and clear
      step(0, 32'h0, 8'h00, 0, 0, 1);
      step(1, 32'hD1, 8'h41, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 32'h0, 8'h00, 0, 0, 0);
      chk("stall_sat", {28'b0, Stall_Cnt}, 32'd15);
      step(0, 32'h0, 8'h00, 0, 0, 1);
      step(0, 32'h0, 8'h00, 1, 0, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);

      // Asynchronous reset mid-cycle while FULL
      step(1, 32'hE1, 8'h51, 0, 0, 0);
      step(1, 32'hE2, 8'h52, 0, 0, 0);
      step(0, 32'h0, 8'h00, 0, 0, 0);
      #2;
      Rst = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      sb.delete();
      m_rdy_en = 1'b0;
      m_cnt = 0;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      step(0, 32'h0, 8'h00, 1, 0, 0);
      step(1, 32'hF1, 8'h61, 1, 0, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);
      step(0, 32'h0, 8'h00, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
